// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op, state and flag encodings for alu_seq
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - shift-add multiplier, one multiplier bit per step
module mul_iter #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [CW-1:0]      count,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // product includes the current step's partial term, so the final step's
    // value is available to the caller at the same edge that consumes it
    assign product = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle ops and iterative multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Buswires,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;

    state_t             state, state_nxt;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CW-1:0]      mul_count;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_last;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res, wr_res;
    logic               alu_c, alu_v, wr_c, wr_v, wr_en;

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (Clock),
                .rst_n   (Resetn),
                .load    (state == ST_IDLE && start),
                .step    (state == ST_MUL),
                .a       (A),
                .b       (Buswires),
                .count   (mul_count),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_count   = '0;
            assign mul_product = '0;
        end
    endgenerate

    assign mul_last = (mul_count == CW'(WIDTH - 1));
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (op == OP_MUL && MUL_EN != 0) ? ST_MUL : ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_MUL:  if (mul_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q >= b_q);
                alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            // MUL only reaches EXEC when the multiplier is not built
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        wr_en  = (state == ST_EXEC) || (state == ST_MUL && mul_last);
        wr_res = alu_res;
        wr_c   = alu_c;
        wr_v   = alu_v;
        if (state == ST_MUL) begin
            wr_res = mul_product[WIDTH-1:0];
            wr_c   = |mul_product[2*WIDTH-1:WIDTH];
            wr_v   = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= ST_IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                op_q <= op_t'(op);
                a_q  <= A;
                b_q  <= Buswires;
            end
            if (wr_en) begin
                result <= wr_res;
                flags  <= pack_flags(wr_res[MSB], wr_res == '0, wr_c, wr_v);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=16
module tb_alu_seq;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Resetn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] Buswires = '0;
    logic         busy, done, busy0, done0;
    logic [W-1:0] result, result0;
    logic [3:0]   flags, flags0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    always #5 Clock = ~Clock;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) u_dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .A(A),
        .Buswires(Buswires), .busy(busy), .done(done), .result(result), .flags(flags)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(0)) u_dut0 (
        .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .A(A),
        .Buswires(Buswires), .busy(busy0), .done(done0), .result(result0), .flags(flags0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {result[15:0], N, Z, C, V} from plain integer arithmetic
    function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        int unsigned     ua = a;
        int unsigned     ub = b;
        int              sa = $signed(a);
        int              sb = $signed(b);
        int unsigned     r = 0;
        longint unsigned p;
        logic            c = 1'b0;
        logic            v = 1'b0;
        logic [15:0]     res;
        case (o)
            3'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            3'd1: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * 2; c = (ua >= 32768); end
            3'd6: begin r = ua / 2; c = (ua % 2 == 1); end
            default: begin
                p = longint'(ua) * longint'(ub);
                r = int'(p % 65536);
                c = ((p / 65536) != 0);
            end
        endcase
        res = r[15:0];
        return {res, res[15], res == 16'h0, c, v};
    endfunction

    task automatic run(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef, input int el,
                       input string tag);
        int n;
        int bc;
        start = 1'b1; op = o; A = a; Buswires = b;
        @(posedge Clock); #1 start = 1'b0;
        n  = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(posedge Clock); #1;
            n++;
            if (busy) bc++;
        end
        check({tag, " latency"}, n, el);
        check({tag, " busy cycles"}, bc, el);
        check({tag, " result"}, result, er);
        check({tag, " flags"}, flags, ef);
        @(posedge Clock); #1;
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " idle after"}, busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          dcount;
        int          consec;
        logic        prev;
        int          n;
        logic [2:0]  ro;
        logic [15:0] ra, rb;
        logic [19:0] m;

        tbl[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 2};
        tbl[1]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 4'b0110, 2};
        tbl[2]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 2};
        tbl[3]  = '{3'd7, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 17};
        tbl[4]  = '{3'd5, 16'h8001, 16'h0000, 16'h0002, 4'b0010, 2};
        tbl[5]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 2};
        tbl[6]  = '{3'd3, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 2};
        tbl[7]  = '{3'd4, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000, 2};
        tbl[8]  = '{3'd6, 16'h0003, 16'h1234, 16'h0001, 4'b0010, 2};
        tbl[9]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 2};
        tbl[10] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 2};
        tbl[11] = '{3'd7, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17};
        tbl[12] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 17};

        #3;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 16'h0);
        check("reset flags", flags, 4'h0);
        @(posedge Clock); #1 Resetn = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 13; i++)
            run(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].fl, tbl[i].lat,
                $sformatf("vec%0d", i));

        // start pulsed while the multiply is running must be ignored
        start = 1'b1; op = 3'd7; A = 16'h0003; Buswires = 16'h0005;
        @(posedge Clock); #1 start = 1'b0;
        dcount = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin start = 1'b1; op = 3'd0; A = 16'h0001; Buswires = 16'h0001; end
            if (i == 6) start = 1'b0;
            @(posedge Clock); #1;
            if (done) dcount++;
        end
        check("busy start done count", dcount, 1);
        check("busy start result", result, 16'h000F);
        check("busy start flags", flags, 4'b0000);

        // start held high: one op accepted per 3-cycle IDLE/EXEC/DONE round
        start = 1'b1; op = 3'd0; A = 16'h0001; Buswires = 16'h0002;
        dcount = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock); #1;
            if (i == 5) start = 1'b0;
            if (done) dcount++;
            if (done && prev) consec++;
            prev = done;
        end
        check("held start done count", dcount, 2);
        check("held start done width", consec, 0);
        check("held start result", result, 16'h0003);

        // reset in the 8th multiply cycle aborts without a done pulse
        start = 1'b1; op = 3'd7; A = 16'hFFFF; Buswires = 16'h0003;
        @(posedge Clock); #1 start = 1'b0;
        repeat (7) @(posedge Clock);
        #1;
        check("pre-reset busy", busy, 1'b1);
        Resetn = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, 16'h0);
        check("abort flags", flags, 4'h0);
        @(posedge Clock); #1 Resetn = 1'b1;
        dcount = 0;
        repeat (25) begin
            @(posedge Clock); #1;
            if (done) dcount++;
        end
        check("abort no done", dcount, 0);
        run(3'd5, 16'h8001, 16'h0000, 16'h0002, 4'b0010, 2, "post-reset shl");

        // build without multiplier: op 111 completes as a 2-cycle zero result
        start = 1'b1; op = 3'd7; A = 16'h1234; Buswires = 16'h5678;
        @(posedge Clock); #1 start = 1'b0;
        n = 1;
        while (!done0 && n < 40) begin
            @(posedge Clock); #1;
            n++;
        end
        check("nomul latency", n, 2);
        check("nomul result", result0, 16'h0);
        check("nomul flags", flags0, 4'b0100);
        n = 0;
        while (busy && n < 40) begin
            @(posedge Clock); #1;
            n++;
        end
        check("nomul main dut idle", busy, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            m  = model(ro, ra, rb);
            run(ro, ra, rb, m[19:4], m[3:0], (ro == 3'd7) ? 17 : 2,
                $sformatf("rand%0d op%0d %h %h", i, ro, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
